// File: rtl/fp_mul_nr_pipe.sv
// fp_mul_nr_pipe: 3-cycle pipelined positive single-precision multiplier for the InvSqrt Newton-Raphson step.
// Operands and result are sign-less {exp[30:23], frac[22:0]}; valid/ready/error sideband passes through.
module fp_mul_nr_pipe #(
    parameter int ROUND_NEAREST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [30:0] float_a,
    input  logic [30:0] float_b,
    input  logic        error_in,
    output logic [30:0] float_out,
    output logic        ready,
    output logic        error_out
);
    localparam logic [30:0] QNAN = 31'h7FC0_0000;
    localparam logic [30:0] INF  = 31'h7F80_0000;

    logic        s1_valid, s1_err, s1_zero_a, s1_zero_b, s1_spec_a, s1_spec_b;
    logic [30:0] s1_a, s1_b;

    logic        s2_valid, s2_err, s2_zero, s2_spec;
    logic [47:0] s2_prod;
    logic [9:0]  s2_e;

    logic        s3_valid, s3_err;
    logic [30:0] s3_out;

    logic        hi, guard, sticky, inc, carry, ovf, unf;
    logic [22:0] mant, frac;
    logic [9:0]  e_n;
    logic [30:0] res;
    logic        st_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_err    <= 1'b0;
            s1_zero_a <= 1'b0;
            s1_zero_b <= 1'b0;
            s1_spec_a <= 1'b0;
            s1_spec_b <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
        end else begin
            s1_valid  <= valid;
            s1_err    <= error_in;
            s1_a      <= float_a;
            s1_b      <= float_b;
            s1_zero_a <= float_a[30:23] == 8'd0;
            s1_zero_b <= float_b[30:23] == 8'd0;
            s1_spec_a <= float_a[30:23] == 8'hFF;
            s1_spec_b <= float_b[30:23] == 8'hFF;
        end
    end

    // Exponent is kept as a 10-bit two's-complement value so underflow shows up in bit 9
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_spec  <= 1'b0;
            s2_prod  <= '0;
            s2_e     <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_err   <= s1_err;
            s2_zero  <= s1_zero_a | s1_zero_b;
            s2_spec  <= s1_spec_a | s1_spec_b;
            s2_prod  <= {1'b1, s1_a[22:0]} * {1'b1, s1_b[22:0]};
            s2_e     <= {2'b00, s1_a[30:23]} + {2'b00, s1_b[30:23]} - 10'd127;
        end
    end

    always_comb begin
        hi            = s2_prod[47];
        mant          = hi ? s2_prod[46:24] : s2_prod[45:23];
        guard         = hi ? s2_prod[23] : s2_prod[22];
        sticky        = hi ? |s2_prod[22:0] : |s2_prod[21:0];
        inc           = (ROUND_NEAREST != 0) && guard && (sticky || mant[0]);
        {carry, frac} = {1'b0, mant} + {23'd0, inc};
        e_n           = s2_e + {9'd0, hi} + {9'd0, carry};
        ovf           = !e_n[9] && e_n >= 10'd255;
        unf           = e_n[9] || e_n == 10'd0;
        res           = s2_spec ? QNAN :
                        s2_zero ? 31'd0 :
                        ovf     ? INF :
                        unf     ? 31'd0 : {e_n[7:0], frac};
        st_err        = s2_spec || (!s2_zero && ovf);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_valid <= 1'b0;
            s3_err   <= 1'b0;
            s3_out   <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_err   <= s2_err | st_err;
            s3_out   <= res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            float_out <= '0;
            ready     <= 1'b0;
            error_out <= 1'b0;
        end else begin
            ready     <= s3_valid;
            error_out <= s3_valid & s3_err;
            if (s3_valid) float_out <= s3_out;
        end
    end
endmodule

// File: doc/fp_mul_nr_pipe.md
Name: fp_mul_nr_pipe

Overview:
- Pipelined positive single-precision multiplier that consumes the result stream of the 1.5-minus subtract stage.
- Computes the Newton-Raphson product y*(1.5 - x*y*y/2). Operand a is the subtract result; operand b is the delayed y carried alongside it.
- Uses the same valid/ready/error sideband protocol on both sides, so it chains directly behind fp_sub_1d5_pipe in the InvSqrt datapath.
- Sign is implicit 0: operands and result are 31-bit {exp[30:23], frac[22:0]}.

Parameters:
- ROUND_NEAREST, 1: 1 = round-to-nearest-even, 0 = truncate.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset. rst=0 clears all state immediately.
- valid  in  1  input sample valid; driven from upstream ready.
- float_a  in  31  operand a; connects to upstream float_out.
- float_b  in  31  operand b; connects to upstream float_out_delay.
- error_in  in  1  upstream error flag; qualified by valid.
- float_out  out  31  product; holds its last value while ready=0.
- ready  out  1  float_out/error_out valid this cycle.
- error_out  out  1  error for this result; qualified by ready, 0 when ready=0.

Behaviour:
- Reset: all pipeline registers cleared; float_out=31'h0, ready=0, error_out=0. Reset mid-stream discards every in-flight sample; no ready pulse is produced for them after release.
- No backpressure. Accepts one sample per cycle. Latency is exactly 3 cycles: a sample with valid=1 at edge n gives ready=1 at edge n+3. Valid gaps propagate as ready gaps.
- Stage 1, capture:
  - register a, b, error_in, valid.
  - classify each operand: zero if exp==0 (denormals flushed to zero); special if exp==255.
- Stage 2, raw product:
  - 48-bit product of {1,frac_a} x {1,frac_b}.
  - 10-bit signed exponent e = ea + eb - 127.
  - carry the flags forward.
- Stage 3, normalise, round, pack:
  - If product[47]=1, take mantissa from product[46:24] with guard product[23], sticky |product[22:0], and e=e+1. Otherwise take mantissa from product[45:23] with guard product[22], sticky |product[21:0].
  - ROUND_NEAREST=1: increment when guard & (sticky | lsb). ROUND_NEAREST=0: never increment.
  - Mantissa carry-out after rounding sets frac=0 and e=e+1.
  - Result selection, highest priority first:
    1. Any special operand: float_out=31'h7FC0_0000, error=1.
    2. Any zero operand: float_out=0, error=0.
    3. e>=255: float_out=31'h7F80_0000, error=1.
    4. e<=0: float_out=0, error=0 (underflow flush).
    5. Otherwise: float_out={e[7:0], frac}.
  - error_out = delayed error_in | stage error. When error_in=1 the product is still computed normally.
- Output register loads only when stage-3 valid=1. ready is the stage-3 valid, registered.

Test Plan:
- Basic values, back-to-back. a=31'h3FC00000 (1.5), b=31'h3F800000 -> float_out=31'h3FC00000. a=31'h40000000, b=31'h40400000 -> 31'h40C00000. Both give ready exactly 3 cycles after valid, error_out=0.
- Rounding.
  - a=b=31'h3F800001 -> 31'h3F800002.
  - a=31'h3F800001, b=31'h3FC00000 (tie case): ROUND_NEAREST=1 -> 31'h3FC00002; ROUND_NEAREST=0 -> 31'h3FC00001.
- Over/underflow. a=31'h7F000000, b=31'h40000000 -> 31'h7F800000, error_out=1. a=31'h00800000, b=31'h3F000000 -> 0, error_out=0.
- Specials and error propagation. a=31'h7F800000, b=31'h3F800000 -> 31'h7FC00000, error_out=1. a=0, b=31'h40000000 -> 0. Valid sample with error_in=1 and 2.0x3.0 -> 31'h40C00000, error_out=1.
- Streaming with gaps. Stream of 10 samples with valid pattern 1101100111 -> ready reproduces the pattern shifted by 3 cycles. float_out holds its value during ready=0.
- Reset mid-stream. Drop rst to 0 with 2 samples in flight -> outputs clear immediately. After release with valid=0, ready stays 0. The first new sample appears 3 cycles after it is accepted.
